// File: rtl/led_string.sv
//------------------------------------------------------------------------------
// Module   : led_string
// Brief    : Continuously refreshes a WS2812-style LED chain from a parallel
//            color vector, one fixed-period pulse per bit plus a latch gap.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_string #(
  parameter int NUM_LEDS     = 144,
  parameter int BITS_PER_LED = 24,
  parameter int BIT_CYCLES   = 60,
  parameter int T0H_CYCLES   = 19,
  parameter int T1H_CYCLES   = 38,
  parameter int RESET_CYCLES = 14400
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_LEDS*BITS_PER_LED-1:0] color_string,
  output logic                             to_light
);

  localparam int TOTAL_BITS = NUM_LEDS * BITS_PER_LED;
  localparam int CNT_MAX    = (RESET_CYCLES > BIT_CYCLES) ? RESET_CYCLES : BIT_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int IDX_W      = $clog2(TOTAL_BITS + 1);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] T0H_LAST  = CNT_W'(T0H_CYCLES - 1);
  localparam logic [CNT_W-1:0] T1H_LAST  = CNT_W'(T1H_CYCLES - 1);
  localparam logic [CNT_W-1:0] T0L_LAST  = CNT_W'(BIT_CYCLES - T0H_CYCLES - 1);
  localparam logic [CNT_W-1:0] T1L_LAST  = CNT_W'(BIT_CYCLES - T1H_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(TOTAL_BITS - 1);

  localparam logic [1:0] ST_LATCH = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LOW   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [TOTAL_BITS-1:0] frame_q, frame_d;
  logic                  to_light_q, to_light_d;

  logic                  cur_bit;
  logic [CNT_W-1:0]      high_last;
  logic [CNT_W-1:0]      low_last;

  // The bit on the wire is always the MSB of the snapshot register.
  assign cur_bit   = frame_q[TOTAL_BITS-1];
  assign high_last = cur_bit ? T1H_LAST : T0H_LAST;
  assign low_last  = cur_bit ? T1L_LAST : T0L_LAST;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_LATCH;
      cnt_q      <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      to_light_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      to_light_q <= to_light_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    frame_d = frame_q;
    case (state_q)
      ST_LATCH: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        state_d = ST_HIGH;
        cnt_d   = '0;
        idx_d   = '0;
        frame_d = color_string;
      end
      ST_HIGH: begin
        if (cnt_q == high_last) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      end
      ST_LOW: begin
        if (cnt_q == low_last) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_LATCH;
          end else begin
            state_d = ST_HIGH;
            idx_d   = idx_q + IDX_W'(1);
            frame_d = {frame_q[TOTAL_BITS-2:0], 1'b0};
          end
        end
      end
      default: begin
        state_d = ST_LATCH;
        cnt_d   = '0;
      end
    endcase
  end

  // Registering the decoded next state keeps the pin aligned with HIGH and glitch-free.
  always_comb begin
    to_light_d = (state_d == ST_HIGH);
  end

  assign to_light = to_light_q;

endmodule

`default_nettype wire

// File: tb/tb_led_string.sv
//------------------------------------------------------------------------------
// Module   : tb_led_string
// Brief    : Directed self-checking bench for led_string on a 6-LED chain.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_led_string;

  localparam int NL    = 6;
  localparam int BPL   = 24;
  localparam int BC    = 60;
  localparam int T0    = 19;
  localparam int T1    = 38;
  localparam int RC    = 400;
  localparam int TOTAL = NL * BPL;
  // 400 latch + 1 load + 144 bits * 60 clocks
  localparam int FRAME_CYC = 9041;

  localparam logic [TOTAL-1:0] PAT_A = {24'h00CEFF, 24'h00CEFF, 24'h00CEFF, 72'h0};
  localparam logic [TOTAL-1:0] ZEROS = '0;
  localparam logic [TOTAL-1:0] ONES  = '1;

  logic             clk;
  logic             rst;
  logic [TOTAL-1:0] color;
  logic             to_light;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  led_string #(
    .NUM_LEDS    (NL),
    .BITS_PER_LED(BPL),
    .BIT_CYCLES  (BC),
    .T0H_CYCLES  (T0),
    .T1H_CYCLES  (T1),
    .RESET_CYCLES(RC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .color_string(color),
    .to_light    (to_light)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Counts clock edges until to_light is seen high.
  task automatic wait_rise(input int max, output int n);
    n = 0;
    while (n <= max) begin
      @(posedge clk);
      #1;
      n++;
      if (to_light) break;
    end
  endtask

  // Entered with to_light just seen high; returns high and low clock counts.
  task automatic measure_bit(input int max_low, output int h, output int l, output bit tmo);
    tmo = 1'b0;
    h   = 1;
    l   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!to_light) break;
      h++;
      if (h > BC) begin
        tmo = 1'b1;
        return;
      end
    end
    l = 1;
    forever begin
      @(posedge clk);
      #1;
      if (to_light) break;
      l++;
      if (l > max_low) begin
        tmo = 1'b1;
        return;
      end
    end
  endtask

  // Checks a whole frame bit by bit; optionally changes color during bit upd_at.
  task automatic frame_check(input string name, input logic [TOTAL-1:0] exp,
                             input int upd_at, input logic [TOTAL-1:0] upd_val,
                             output int start_cyc);
    int h, l, eh, el;
    bit tmo;
    start_cyc = cyc;
    for (int i = 0; i < TOTAL; i++) begin
      measure_bit(RC + BC + 10, h, l, tmo);
      if (i == upd_at) color = upd_val;
      eh = exp[TOTAL-1-i] ? T1 : T0;
      el = (i == TOTAL - 1) ? (BC - eh + RC + 1) : (BC - eh);
      check($sformatf("%s_bit%0d_high", name, i), h, eh);
      if (tmo) begin
        check($sformatf("%s_bit%0d_timeout", name, i), 1, 0);
        return;
      end
      check($sformatf("%s_bit%0d_low", name, i), l, el);
    end
  endtask

  initial begin
    int n, f1, f2, f3, f4, f5;
    rst   = 1'b1;
    color = PAT_A;
    #1 rst = 1'b0;
    #1 check("rst_async", int'(to_light), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_hold", int'(to_light), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    wait_rise(RC + BC, n);
    check("first_latch", n, RC + 1);

    frame_check("fA", PAT_A, -1, ZEROS, f1);
    frame_check("fA_upd", PAT_A, 100, ZEROS, f2);
    frame_check("fZ", ZEROS, 5, ONES, f3);
    frame_check("fO", ONES, -1, ZEROS, f4);
    check("frame_spacing_12", f2 - f1, FRAME_CYC);
    check("frame_spacing_23", f3 - f2, FRAME_CYC);
    check("frame_spacing_34", f4 - f3, FRAME_CYC);

    // Frame 5 has just started its first pulse: reset off the clock edge.
    check("pre_reset_high", int'(to_light), 1);
    #2 rst = 1'b0;
    #1 check("mid_pulse_reset", int'(to_light), 0);
    color = PAT_A;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_rise(RC + BC, n);
    check("latch_after_reset", n, RC + 1);
    frame_check("fR", PAT_A, -1, ZEROS, f5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
